// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst read/write controller for a 256x32 single-port RAM with a 2-entry read buffer
`timescale 1ns/1ps
module ram_burst_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic              ram_rw_o,
  input  logic [DATA_W-1:0] ram_dout_i
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic inflight_q, inflight_d;
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0] cnt_q, cnt_d, occ, occ_left, cnt_mid;
  logic pop, issue;
  assign pop = rd_valid_o & rd_ready_i;
  assign occ = cnt_q + {1'b0, inflight_q};
  assign occ_left = occ - {1'b0, pop};
  assign cnt_mid = cnt_q - {1'b0, pop};
  assign issue = (state_q == READ) && (remain_q != '0) && (occ_left < 2'd2);
  assign req_ready_o = state_q == IDLE;
  assign wr_ready_o = state_q == WRITE;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign rd_valid_o = cnt_q != 2'd0;
  assign rd_data_o = buf0_q;
  assign ram_addr_o = cur_addr_q;
  assign ram_din_o = wr_data_i;
  assign ram_rw_o = (state_q == WRITE) && wr_valid_i;
  // Output FIFO: shift on pop, land the in-flight RAM word behind whatever remains
  always_comb begin
    buf0_d = pop ? buf1_q : buf0_q;
    buf1_d = buf1_q;
    if (inflight_q) begin
      if (cnt_mid == 2'd0) buf0_d = ram_dout_i;
      else buf1_d = ram_dout_i;
    end
    cnt_d = cnt_mid + {1'b0, inflight_q};
  end
  // Burst sequencing: address/length bookkeeping and state transitions
  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    remain_d = remain_q;
    inflight_d = issue;
    case (state_q)
      IDLE: if (req_valid_i) begin
        cur_addr_d = req_addr_i;
        remain_d = req_len_i;
        state_d = (req_len_i == '0) ? DONE : req_write_i ? WRITE : READ;
      end
      WRITE: if (wr_valid_i) begin
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        remain_d = remain_q - LEN_W'(1);
        if (remain_q == LEN_W'(1)) state_d = DONE;
      end
      READ: begin
        if (issue) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
        end
        if (remain_q == '0 && !inflight_q && cnt_q == 2'd0) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cur_addr_q <= '0;
      remain_q <= '0;
      inflight_q <= 1'b0;
      cnt_q <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q <= remain_d;
      inflight_q <= inflight_d;
      cnt_q <= cnt_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: randomized self-checking bench with a RAM model and a reference memory image
`timescale 1ns/1ps
module tb_ram_burst_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [7:0] req_addr = 0;
  logic [8:0] req_len = 0;
  logic wr_valid = 0, wr_ready;
  logic [31:0] wr_data = 0;
  logic rd_valid, rd_ready = 0;
  logic [31:0] rd_data;
  logic busy, done;
  logic [7:0] ram_addr;
  logic [31:0] ram_din;
  logic ram_rw;
  logic [31:0] ram_dout = 0;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [39:0] wlog [$];
  logic [31:0] wq [$];

  ram_burst_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .busy_o(busy), .done_o(done),
    .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_rw_o(ram_rw), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rw) begin
      mem[ram_addr] <= ram_din;
      wlog.push_back({ram_addr, ram_din});
    end else ram_dout <= mem[ram_addr];
    if (done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [7:0] a, input int len, input bit gaps);
    int idx = 0, cyc = 0, d0 = done_cnt;
    wlog.delete();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_req_ready: got %b expected 1", req_ready); end
    req_valid = 1; req_write = 1; req_addr = a; req_len = 9'(len);
    @(negedge clk);
    req_valid = 0;
    while (idx < len && cyc < 4000) begin
      wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data = wq[idx];
      if (wr_valid && wr_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    wr_valid = 0;
    checks++; if (idx != len) begin errors++; $display("FAIL wr_timeout: got %0d words expected %0d", idx, len); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wr_done_timing: got %b expected 1", done); end
    if (!gaps) begin
      checks++; if (cyc != len) begin errors++; $display("FAIL wr_throughput: got %0d cycles expected %0d", cyc, len); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wr_after_done: got done=%b ready=%b busy=%b expected 0 1 0", done, req_ready, busy); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (wlog.size() != len) begin errors++; $display("FAIL wr_ram_count: got %0d expected %0d", wlog.size(), len); end
    for (int i = 0; i < len && i < wlog.size(); i++) begin
      logic [7:0] ea;
      ea = a + 8'(i);
      checks++; if (wlog[i] !== {ea, wq[i]}) begin errors++; $display("FAIL wr_ram_beat%0d: got %h expected %h", i, wlog[i], {ea, wq[i]}); end
      ref_mem[ea] = wq[i];
    end
  endtask

  task automatic do_read(input logic [7:0] a, input int len, input int mode);
    int n = 0, cyc = 0, ph = 0, k = 0, d0 = done_cnt;
    bit started = 0;
    wlog.delete();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_req_ready: got %b expected 1", req_ready); end
    req_valid = 1; req_write = 0; req_addr = a; req_len = 9'(len);
    @(negedge clk);
    req_valid = 0;
    while (n < len && cyc < 4000) begin
      rd_ready = mode == 0 ? 1'b1 : mode == 1 ? (ph % 3 == 0) : 1'($urandom_range(0, 1));
      ph++;
      if (mode == 0 && started) begin
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_stream_gap: got %b expected 1 at word %0d", rd_valid, n); end
      end
      if (rd_valid && rd_ready) begin
        logic [7:0] ea;
        ea = a + 8'(n);
        checks++; if (rd_data !== ref_mem[ea]) begin errors++; $display("FAIL rd_word%0d: got %h expected %h", n, rd_data, ref_mem[ea]); end
        n++;
        started = 1;
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1;
    checks++; if (n != len) begin errors++; $display("FAIL rd_timeout: got %0d words expected %0d", n, len); end
    while (!done && k < 4) begin
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_extra_word: got rd_valid %b expected 0", rd_valid); end
      @(negedge clk);
      k++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rd_done: got %b expected 1", done); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_at_done: got %b expected 0", rd_valid); end
    @(negedge clk);
    rd_ready = 0;
    checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rd_after_done: got done=%b ready=%b expected 0 1", done, req_ready); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rd_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL rd_ram_write: got %0d writes expected 0", wlog.size()); end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 256; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, rd_valid, wr_ready, ram_rw} !== 5'b0 || ram_addr !== 8'h00) begin errors++; $display("FAIL reset_outputs: got %b addr %h expected 00000 addr 00", {busy, done, rd_valid, wr_ready, ram_rw}, ram_addr); end
    rst = 0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_basic;
    wq = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(8'h00, 4, 0);
    do_read(8'h00, 4, 0);
  endtask

  task automatic test_wrap;
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back($urandom);
    do_write(8'hFE, 4, 0);
    do_read(8'hFE, 4, 0);
  endtask

  task automatic test_backpressure;
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    do_write(8'h10, 8, 1);
    do_read(8'h10, 8, 1);
    do_read(8'h10, 8, 2);
  endtask

  task automatic test_zero_len;
    wr_valid = 1;
    wq.delete();
    do_read(8'h33, 0, 0);
    do_read(8'h10, 3, 0);
    wr_valid = 0;
    do_write(8'h55, 0, 0);
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt;
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back($urandom);
    wlog.delete();
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 8'h40; req_len = 9'd6;
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_data = wq[i];
      @(negedge clk);
    end
    wr_data = wq[3];
    rst = 1;
    #1;
    checks++; if (ram_rw !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_immediate: got rw=%b busy=%b wr_ready=%b expected 0 0 0", ram_rw, busy, wr_ready); end
    repeat (2) @(negedge clk);
    rst = 0; wr_valid = 0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", req_ready); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_reset_done: got %0d pulses expected 0", done_cnt - d0); end
    checks++; if (wlog.size() != 3) begin errors++; $display("FAIL mid_reset_writes: got %0d expected 3", wlog.size()); end
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      checks++; if (wlog[i] !== {8'h40 + 8'(i), wq[i]}) begin errors++; $display("FAIL mid_reset_beat%0d: got %h expected %h", i, wlog[i], {8'h40 + 8'(i), wq[i]}); end
      ref_mem[8'h40 + 8'(i)] = wq[i];
    end
    do_read(8'h40, 2, 0);
    do_read(8'h42, 2, 2);
  endtask

  task automatic test_full;
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
    do_write(8'h80, 256, 0);
    do_read(8'h80, 256, 0);
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
    do_write(8'h80, 256, 1);
    do_read(8'h37, 256, 2);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_zero_len;
    test_reset_mid;
    test_full;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst access controller that sits directly upstream of `RAM_256x32` and is the only block driving its `Addr`, `DataIn` and `RW` pins. It accepts one burst request at a time (start address, length, direction) over a valid/ready handshake. Writes stream in on a write-data channel; reads stream out on a back-pressurable read-data channel. A 2-entry output buffer absorbs the RAM's one-cycle read latency, so both directions sustain one word per cycle.

## Interface
- `ADDR_W`, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 32, word width.
- `LEN_W`, 9, burst length field width; legal lengths 0..256.

- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  burst request present.
- `req_ready`  out  1  controller accepts a request; high only in IDLE.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  ADDR_W  start address.
- `req_len`  in  LEN_W  word count.
- `wr_valid`  in  1  write word present.
- `wr_ready`  out  1  write word accepted; high only in WRITE.
- `wr_data`  in  DATA_W  write word.
- `rd_valid`  out  1  read word available (output buffer non-empty).
- `rd_ready`  in  1  consumer takes read word.
- `rd_data`  out  DATA_W  head of output buffer.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at burst completion.
- `ram_addr`  out  ADDR_W  to RAM `Addr`.
- `ram_din`  out  DATA_W  to RAM `DataIn`.
- `ram_rw`  out  1  to RAM `RW`; 1 = write on this rising edge, 0 = read.
- `ram_dout`  in  DATA_W  from RAM `DataOut`; valid the cycle after a read address is presented.

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: `req_ready`=1. On `req_valid`, latch `cur_addr`=`req_addr` and `remain`=`req_len`. If `req_len`==0, go to DONE. Otherwise go to WRITE or READ per `req_write`.
- WRITE:
  - `wr_ready`=1; `ram_rw`=`wr_valid`, `ram_addr`=`cur_addr`, `ram_din`=`wr_data` (combinational).
  - Each accepted word: `cur_addr`+1 (8-bit wrap, 255→0), `remain`−1.
  - Last word accepted (`remain`==1) → DONE.
- READ:
  - `ram_rw`=0 always. `occ` = buffer count + in-flight flag (0..2); `pop` = `rd_valid` & `rd_ready`.
  - Issue a read (present `cur_addr`, set in-flight for the next cycle, increment `cur_addr`, decrement `remain`) when `remain`!=0 and `occ`−`pop` < 2.
  - In-flight data is written into the buffer from `ram_dout` one cycle after issue.
  - Go to DONE when `remain`==0, in-flight==0, buffer empty.
- DONE: `done`=1 for exactly one cycle, then IDLE. `req_ready`=0 in DONE.
- `ram_addr` holds `cur_addr` when idle; `ram_din`=`wr_data` always. `ram_rw` is 0 in every state except an accepted WRITE beat.
- Buffer simultaneous push and pop: count unchanged; order preserved (FIFO).
- A request of length 256 from any address touches every location exactly once.
- `wr_valid` outside WRITE and `rd_ready` with an empty buffer are ignored.

## Timing
- Reset (async, immediate):
  - State → IDLE; `cur_addr`, `remain`, buffer and in-flight flag cleared.
  - `busy`=0, `done`=0, `rd_valid`=0, `wr_ready`=0, `ram_rw`=0, `ram_addr`=0, `req_ready`=1 once `RST` deasserts.
- Reset mid-burst aborts: no `done`, buffered read words discarded, no further RAM writes.
- Request accepted at edge N → WRITE/READ from N; first RAM access at edge N+1.
- Write latency: word accepted at edge K is written into RAM at edge K. `done` is high in cycle K+1 after the last word.
- Read latency: address issued at edge K; word enters buffer at K+1; `rd_valid` high in cycle K+1.
- Throughput: 1 word/cycle in both directions with `wr_valid`/`rd_ready` held high.
- Earliest new request: the cycle after `done`.

## Test plan
- Write burst addr 0x00 len 4, data 0xA0..0xA3 back-to-back → `ram_rw`=1 for 4 consecutive edges at addrs 0..3; `done` one cycle later; then read addr 0 len 4 returns 0xA0..0xA3 on consecutive cycles.
- Wrap: write addr 0xFE len 4 → RAM writes at 0xFE, 0xFF, 0x00, 0x01; read-back in the same order.
- Read addr 0x10 len 8 with `rd_ready` toggling 1,0,0,1,… → no word lost or duplicated; `occ` never exceeds 2; 8 words in address order; `done` after 8th pop.
- `req_len`=0 → `done` pulse the cycle after acceptance; no `ram_rw` assertion; no `rd_valid`.
- Assert `RST` after 3 of 6 write words → RAM writes stop immediately; no `done`; `req_ready`=1 after release; a fresh len-2 read completes normally.
- Full 256-word write with `$random` data from addr 0x80, then full read → all 256 words match; `done` fires once per burst.
